// File: rtl/i2s_rx_pair.sv
// I2S / left-justified serial audio receiver, fully synchronous to CLK_IN.
// Frames SDATA with the generator's Brise/LRrise/LRfall strobes and emits left/right pairs on valid/ready.
module i2s_rx_pair #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_BITS  = 32,
    parameter int I2S_DELAY  = 1
) (
    input  logic                  CLK_IN,
    input  logic                  reset,
    input  logic                  Brise,
    input  logic                  LRrise,
    input  logic                  LRfall,
    input  logic                  SDATA,
    output logic [DATA_WIDTH-1:0] L_DATA,
    output logic [DATA_WIDTH-1:0] R_DATA,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);

    localparam int IW = $clog2(SLOT_BITS + 1);
    localparam logic [IW-1:0] C_SLOT_MAX = IW'(SLOT_BITS);
    localparam logic [IW-1:0] C_LAST_IDX = IW'(DATA_WIDTH + I2S_DELAY - 1);

    // state    | meaning
    // ST_SYNC  | after reset, waiting for the first LRfall
    // ST_LEFT  | receiving the left slot
    // ST_RIGHT | receiving the right slot
    // ST_WAIT_L| duplicate LRrise seen, waiting for LRfall to resync
    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_LEFT   = 2'd1,
        ST_RIGHT  = 2'd2,
        ST_WAIT_L = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [IW-1:0]         r_bit_idx;
    logic [IW-1:0]         w_idx;
    logic [IW-1:0]         w_idx_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [DATA_WIDTH-1:0] r_left_hold;
    logic [DATA_WIDTH-1:0] r_right_hold;
    logic [DATA_WIDTH-1:0] r_l_data;
    logic [DATA_WIDTH-1:0] r_r_data;
    logic                  r_left_ok;
    logic                  r_pair_pend;
    logic                  r_out_valid;
    logic                  r_overrun;

    logic                  w_lr;
    logic                  w_in_window;
    logic                  w_capture;
    logic                  w_complete;
    logic                  w_left_done;
    logic                  w_pair_done;

    // A Brise coinciding with an LR strobe is bit 0 of the new slot.
    assign w_lr         = LRfall | LRrise;
    assign w_idx        = w_lr ? '0 : r_bit_idx;
    assign w_in_window  = (int'(w_idx) >= I2S_DELAY) && (int'(w_idx) < DATA_WIDTH + I2S_DELAY);
    assign w_capture    = Brise & w_in_window;
    assign w_complete   = Brise && (w_idx == C_LAST_IDX);
    assign w_shift_next = DATA_WIDTH'({r_shift, SDATA});
    assign w_idx_next   = (Brise && (w_idx != C_SLOT_MAX)) ? w_idx + IW'(1) : w_idx;

    always_ff @(posedge CLK_IN) begin
        if (reset) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (LRfall) begin
            w_state_next = ST_LEFT;
        end else if (LRrise) begin
            case (r_state)
                ST_LEFT:  w_state_next = ST_RIGHT;
                ST_RIGHT: w_state_next = ST_WAIT_L;
                default:  w_state_next = r_state;
            endcase
        end
    end

    // Completion belongs to the slot the strobe (if any) has just opened.
    assign w_left_done = w_complete && (w_state_next == ST_LEFT);
    assign w_pair_done = w_complete && (w_state_next == ST_RIGHT) && r_left_ok;

    always_ff @(posedge CLK_IN) begin
        if (reset) begin
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_left_hold  <= '0;
            r_right_hold <= '0;
            r_left_ok    <= 1'b0;
            r_pair_pend  <= 1'b0;
        end else begin
            r_bit_idx   <= w_idx_next;
            r_pair_pend <= w_pair_done;
            if (w_capture) begin
                r_shift <= w_shift_next;
            end
            if (w_left_done) begin
                r_left_hold <= w_shift_next;
                r_left_ok   <= 1'b1;
            end else if (LRfall) begin
                r_left_ok <= 1'b0;
            end
            if (w_pair_done) begin
                r_right_hold <= w_shift_next;
            end
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (reset) begin
            r_l_data    <= '0;
            r_r_data    <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (r_pair_pend) begin
            if (!r_out_valid || out_ready) begin
                r_l_data    <= r_left_hold;
                r_r_data    <= r_right_hold;
                r_out_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign L_DATA    = r_l_data;
    assign R_DATA    = r_r_data;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_i2s_rx_pair.sv
// Bench for i2s_rx_pair: three builds (I2S 24-bit, left-justified 24-bit, left-justified 8-bit)
// share one strobe/data stream; expected words are extracted from the driven bit stream.
module tb_i2s_rx_pair;

    logic CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    logic reset  = 1'b1;
    logic Brise  = 1'b0;
    logic LRrise = 1'b0;
    logic LRfall = 1'b0;
    logic SDATA  = 1'b0;
    logic rdy_a  = 1'b0;
    logic rdy_b  = 1'b0;
    logic rdy_c  = 1'b0;

    logic [23:0] l_a, r_a, l_b, r_b;
    logic [7:0]  l_c, r_c;
    logic        v_a, v_b, v_c, ov_a, ov_b, ov_c;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] left_bits;
    logic [63:0] right_bits;

    logic       mon_en = 1'b0;
    logic [7:0] q_l[$];
    logic [7:0] q_r[$];

    i2s_rx_pair #(.DATA_WIDTH(24), .SLOT_BITS(32), .I2S_DELAY(1)) u_dut_a (
        .CLK_IN(CLK_IN), .reset(reset), .Brise(Brise), .LRrise(LRrise), .LRfall(LRfall),
        .SDATA(SDATA), .L_DATA(l_a), .R_DATA(r_a), .out_valid(v_a), .out_ready(rdy_a),
        .overrun(ov_a));

    i2s_rx_pair #(.DATA_WIDTH(24), .SLOT_BITS(32), .I2S_DELAY(0)) u_dut_b (
        .CLK_IN(CLK_IN), .reset(reset), .Brise(Brise), .LRrise(LRrise), .LRfall(LRfall),
        .SDATA(SDATA), .L_DATA(l_b), .R_DATA(r_b), .out_valid(v_b), .out_ready(rdy_b),
        .overrun(ov_b));

    i2s_rx_pair #(.DATA_WIDTH(8), .SLOT_BITS(32), .I2S_DELAY(0)) u_dut_c (
        .CLK_IN(CLK_IN), .reset(reset), .Brise(Brise), .LRrise(LRrise), .LRfall(LRfall),
        .SDATA(SDATA), .L_DATA(l_c), .R_DATA(r_c), .out_valid(v_c), .out_ready(rdy_c),
        .overrun(ov_c));

    always @(negedge CLK_IN) begin
        if (mon_en && v_c && rdy_c) begin
            q_l.push_back(l_c);
            q_r.push_back(r_c);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Word as the receiver should see it: width bits starting at slot bit 'delay', MSB first.
    function automatic logic [31:0] exp_word(input logic [63:0] bits, input int delay, input int width);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < width; i++) w = {w[30:0], bits[delay + i]};
        return w;
    endfunction

    function automatic logic [63:0] make_bits(input logic [31:0] word, input int n, input int delay,
                                              input int width);
        logic [63:0] b;
        b = '0;
        for (int j = 0; j < 64; j++) begin
            if (j < n && j >= delay && (j - delay) < width) b[j] = word[width - 1 - (j - delay)];
            else b[j] = 1'($urandom);
        end
        return b;
    endfunction

    task automatic drive_bclk(input int div, input bit lrf, input bit lrr, input bit sd);
        for (int c = 0; c < div; c++) begin
            @(negedge CLK_IN);
            LRfall = lrf && (c == 0);
            LRrise = lrr && (c == 0);
            Brise  = (c == div / 2 - 1);
            SDATA  = sd;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK_IN);
            Brise  = 1'b0;
            LRfall = 1'b0;
            LRrise = 1'b0;
        end
    endtask

    task automatic send_half(input int div, input bit is_left, input int n, input logic [63:0] bits);
        for (int j = 0; j < n; j++) drive_bclk(div, is_left && (j == 0), !is_left && (j == 0), bits[j]);
    endtask

    task automatic send_frame(input int div, input int n, input logic [31:0] lw, input logic [31:0] rw,
                              input int delay, input int width);
        left_bits = make_bits(lw, n, delay, width);
        send_half(div, 1'b1, n, left_bits);
        right_bits = make_bits(rw, n, delay, width);
        send_half(div, 1'b0, n, right_bits);
    endtask

    task automatic do_reset();
        @(negedge CLK_IN);
        reset  = 1'b1;
        Brise  = 1'b0;
        LRfall = 1'b0;
        LRrise = 1'b0;
        rdy_a  = 1'b0;
        rdy_b  = 1'b0;
        rdy_c  = 1'b0;
        repeat (2) @(negedge CLK_IN);
        reset = 1'b0;
    endtask

    task automatic accept_all();
        @(negedge CLK_IN);
        rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
        @(negedge CLK_IN);
        rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge CLK_IN);
        n_cmp++; if (v_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid_a got %b want 0", v_a); end
        n_cmp++; if (ov_a !== 1'b0) begin n_bad++; $display("FAIL reset_overrun_a got %b want 0", ov_a); end
        n_cmp++; if (l_a !== 24'h0 || r_a !== 24'h0) begin n_bad++; $display("FAIL reset_data_a got %h/%h want 0/0", l_a, r_a); end
        n_cmp++; if ({v_b, ov_b, v_c, ov_c} !== 4'b0) begin n_bad++; $display("FAIL reset_flags_bc got %b want 0000", {v_b, ov_b, v_c, ov_c}); end
        @(negedge CLK_IN);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] e_l, e_r;
        int          k;
        bit          seen;
        bit          align;
        logic [31:0] lw, rw;
        do_reset();
        // Stray right slot before any LRfall must be ignored.
        for (int j = 0; j < 5; j++) drive_bclk(4, 1'b0, (j == 0), 1'($urandom));
        left_bits = make_bits(32'hA5C3E1, 32, 1, 24);
        send_half(4, 1'b1, 32, left_bits);
        right_bits = make_bits(32'h123456, 32, 1, 24);
        for (int j = 0; j < 32; j++) begin
            if (j == 24) begin
                fork
                    drive_bclk(4, 1'b0, 1'b0, right_bits[24]);
                    begin
                        seen = 1'b0;
                        k = 0;
                        while (!seen && k < 8) begin
                            @(posedge CLK_IN);
                            seen = (Brise === 1'b1);
                            k++;
                        end
                        #1;
                        n_cmp++; if (!seen || v_a !== 1'b0) begin n_bad++; $display("FAIL latency_early got valid=%b seen=%b want 0/1", v_a, seen); end
                        @(posedge CLK_IN);
                        #1;
                        n_cmp++; if (v_a !== 1'b1) begin n_bad++; $display("FAIL latency_rise got valid=%b want 1", v_a); end
                    end
                join
            end else begin
                drive_bclk(4, 1'b0, (j == 0), right_bits[j]);
            end
        end
        idle(2);
        e_l = exp_word(left_bits, 1, 24); e_r = exp_word(right_bits, 1, 24);
        n_cmp++; if (l_a !== e_l[23:0] || r_a !== e_r[23:0]) begin n_bad++; $display("FAIL first_pair_i2s got %h/%h want %h/%h", l_a, r_a, e_l[23:0], e_r[23:0]); end
        e_l = exp_word(left_bits, 0, 24); e_r = exp_word(right_bits, 0, 24);
        n_cmp++; if (v_b !== 1'b1 || l_b !== e_l[23:0] || r_b !== e_r[23:0]) begin n_bad++; $display("FAIL first_pair_lj got v=%b %h/%h want 1 %h/%h", v_b, l_b, r_b, e_l[23:0], e_r[23:0]); end
        e_l = exp_word(left_bits, 0, 8); e_r = exp_word(right_bits, 0, 8);
        n_cmp++; if (v_c !== 1'b1 || l_c !== e_l[7:0] || r_c !== e_r[7:0]) begin n_bad++; $display("FAIL first_pair_8b got v=%b %h/%h want 1 %h/%h", v_c, l_c, r_c, e_l[7:0], e_r[7:0]); end
        accept_all();
        n_cmp++; if (v_a !== 1'b0) begin n_bad++; $display("FAIL first_accept got valid=%b want 0", v_a); end
        for (int f = 0; f < 4; f++) begin
            lw = 32'($urandom_range(0, 32'hFFFFFF));
            rw = 32'($urandom_range(0, 32'hFFFFFF));
            align = 1'($urandom);
            send_frame(4, 32, lw, rw, align ? 1 : 0, 24);
            idle(2);
            e_l = exp_word(left_bits, 1, 24); e_r = exp_word(right_bits, 1, 24);
            n_cmp++; if (v_a !== 1'b1 || l_a !== e_l[23:0] || r_a !== e_r[23:0]) begin n_bad++; $display("FAIL rand_i2s[%0d] got v=%b %h/%h want 1 %h/%h", f, v_a, l_a, r_a, e_l[23:0], e_r[23:0]); end
            e_l = exp_word(left_bits, 0, 24); e_r = exp_word(right_bits, 0, 24);
            n_cmp++; if (v_b !== 1'b1 || l_b !== e_l[23:0] || r_b !== e_r[23:0]) begin n_bad++; $display("FAIL rand_lj[%0d] got v=%b %h/%h want 1 %h/%h", f, v_b, l_b, r_b, e_l[23:0], e_r[23:0]); end
            accept_all();
            n_cmp++; if (v_a !== 1'b0 || ov_a !== 1'b0) begin n_bad++; $display("FAIL rand_accept[%0d] got v=%b ov=%b want 0/0", f, v_a, ov_a); end
        end
    endtask

    task automatic test_overrun();
        logic [31:0] p1_l, p1_r, e_l, e_r;
        do_reset();
        send_frame(4, 32, 32'($urandom_range(0, 32'hFFFFFF)), 32'($urandom_range(0, 32'hFFFFFF)), 1, 24);
        idle(2);
        p1_l = exp_word(left_bits, 1, 24); p1_r = exp_word(right_bits, 1, 24);
        n_cmp++; if (v_a !== 1'b1 || ov_a !== 1'b0) begin n_bad++; $display("FAIL ovr_first got v=%b ov=%b want 1/0", v_a, ov_a); end
        send_frame(4, 32, 32'($urandom_range(0, 32'hFFFFFF)), 32'($urandom_range(0, 32'hFFFFFF)), 1, 24);
        idle(2);
        n_cmp++; if (l_a !== p1_l[23:0] || r_a !== p1_r[23:0]) begin n_bad++; $display("FAIL ovr_hold got %h/%h want %h/%h", l_a, r_a, p1_l[23:0], p1_r[23:0]); end
        n_cmp++; if (ov_a !== 1'b1 || v_a !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got ov=%b v=%b want 1/1", ov_a, v_a); end
        accept_all();
        n_cmp++; if (v_a !== 1'b0 || ov_a !== 1'b1) begin n_bad++; $display("FAIL ovr_accept got v=%b ov=%b want 0/1", v_a, ov_a); end
        send_frame(4, 32, 32'($urandom_range(0, 32'hFFFFFF)), 32'($urandom_range(0, 32'hFFFFFF)), 1, 24);
        idle(2);
        e_l = exp_word(left_bits, 1, 24); e_r = exp_word(right_bits, 1, 24);
        n_cmp++; if (v_a !== 1'b1 || l_a !== e_l[23:0] || r_a !== e_r[23:0]) begin n_bad++; $display("FAIL ovr_third got v=%b %h/%h want 1 %h/%h", v_a, l_a, r_a, e_l[23:0], e_r[23:0]); end
        accept_all();
    endtask

    task automatic test_reset_mid();
        logic [31:0] e_l, e_r;
        do_reset();
        send_frame(4, 32, 32'($urandom_range(0, 32'hFFFFFF)), 32'($urandom_range(0, 32'hFFFFFF)), 1, 24);
        idle(2);
        n_cmp++; if (v_a !== 1'b1) begin n_bad++; $display("FAIL rmid_pending got v=%b want 1", v_a); end
        left_bits = make_bits(32'($urandom_range(0, 32'hFFFFFF)), 32, 1, 24);
        for (int j = 0; j < 5; j++) drive_bclk(4, (j == 0), 1'b0, left_bits[j]);
        @(negedge CLK_IN);
        reset = 1'b1;
        Brise = 1'b0;
        @(negedge CLK_IN);
        n_cmp++; if ({v_a, ov_a, v_b, v_c} !== 4'b0 || l_a !== 24'h0 || r_a !== 24'h0) begin n_bad++; $display("FAIL rmid_in_reset got v=%b ov=%b %h/%h want 0 0 0/0", v_a, ov_a, l_a, r_a); end
        @(negedge CLK_IN);
        reset = 1'b0;
        for (int j = 5; j < 32; j++) drive_bclk(4, 1'b0, 1'b0, left_bits[j]);
        right_bits = make_bits(32'($urandom_range(0, 32'hFFFFFF)), 32, 1, 24);
        send_half(4, 1'b0, 32, right_bits);
        idle(2);
        n_cmp++; if ({v_a, ov_a, v_b, v_c} !== 4'b0) begin n_bad++; $display("FAIL rmid_no_output got %b want 0000", {v_a, ov_a, v_b, v_c}); end
        send_frame(4, 32, 32'($urandom_range(0, 32'hFFFFFF)), 32'($urandom_range(0, 32'hFFFFFF)), 1, 24);
        idle(2);
        e_l = exp_word(left_bits, 1, 24); e_r = exp_word(right_bits, 1, 24);
        n_cmp++; if (v_a !== 1'b1 || l_a !== e_l[23:0] || r_a !== e_r[23:0]) begin n_bad++; $display("FAIL rmid_resync got v=%b %h/%h want 1 %h/%h", v_a, l_a, r_a, e_l[23:0], e_r[23:0]); end
        accept_all();
    endtask

    task automatic test_short_left();
        logic [31:0] e_l, e_r;
        do_reset();
        send_frame(4, 32, 32'($urandom_range(0, 32'hFFFFFF)), 32'($urandom_range(0, 32'hFFFFFF)), 1, 24);
        idle(2);
        accept_all();
        left_bits = make_bits(32'($urandom_range(0, 32'hFFFFFF)), 10, 1, 24);
        send_half(4, 1'b1, 10, left_bits);
        right_bits = make_bits(32'($urandom_range(0, 32'hFFFFFF)), 32, 1, 24);
        send_half(4, 1'b0, 32, right_bits);
        idle(2);
        n_cmp++; if (v_a !== 1'b0 || ov_a !== 1'b0) begin n_bad++; $display("FAIL short_drop got v=%b ov=%b want 0/0", v_a, ov_a); end
        n_cmp++; if (v_b !== 1'b0 || ov_b !== 1'b0) begin n_bad++; $display("FAIL short_drop_lj got v=%b ov=%b want 0/0", v_b, ov_b); end
        send_frame(4, 32, 32'($urandom_range(0, 32'hFFFFFF)), 32'($urandom_range(0, 32'hFFFFFF)), 1, 24);
        idle(2);
        e_l = exp_word(left_bits, 1, 24); e_r = exp_word(right_bits, 1, 24);
        n_cmp++; if (v_a !== 1'b1 || ov_a !== 1'b0 || l_a !== e_l[23:0] || r_a !== e_r[23:0]) begin n_bad++; $display("FAIL short_next got v=%b ov=%b %h/%h want 1 0 %h/%h", v_a, ov_a, l_a, r_a, e_l[23:0], e_r[23:0]); end
        accept_all();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  e_lq[$];
        logic [7:0]  e_rq[$];
        logic [31:0] e_l, e_r;
        logic [31:0] lw, rw;
        do_reset();
        q_l.delete();
        q_r.delete();
        @(negedge CLK_IN);
        rdy_c  = 1'b1;
        mon_en = 1'b1;
        for (int f = 0; f < 5; f++) begin
            if (f == 0 || f == 1) begin lw = 32'h5A; rw = 32'hC3; end
            else begin lw = 32'($urandom_range(0, 255)); rw = 32'($urandom_range(0, 255)); end
            if (f == 0) send_frame(4, 32, lw, rw, 0, 8);
            else send_frame(2, 8, lw, rw, 0, 8);
            e_l = exp_word(left_bits, 0, 8); e_r = exp_word(right_bits, 0, 8);
            e_lq.push_back(e_l[7:0]);
            e_rq.push_back(e_r[7:0]);
        end
        idle(4);
        mon_en = 1'b0;
        n_cmp++; if (q_l.size() != 5) begin n_bad++; $display("FAIL b2b_count got %0d want 5", q_l.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < q_l.size()) begin
                n_cmp++; if (q_l[i] !== e_lq[i] || q_r[i] !== e_rq[i]) begin n_bad++; $display("FAIL b2b_pair[%0d] got %h/%h want %h/%h", i, q_l[i], q_r[i], e_lq[i], e_rq[i]); end
            end
        end
        n_cmp++; if (ov_c !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun got %b want 0", ov_c); end
        rdy_c = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_reset_mid();
        test_short_left();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
